// File: rtl/seqdiv.sv
// Sequential restoring divider: quot/rem of a1 / a2 in N_LEN+2 cycles, arm/fin handshake.
// Define SEQDIV_SIGNED_EN for two's-complement operands and results; otherwise unsigned.
module seqdiv #(
    parameter int unsigned N_LEN   = 32,
    parameter int unsigned D_LEN   = 32,
    parameter int unsigned CNT_SIZ = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm,
    input  logic [N_LEN-1:0] a1,
    input  logic [D_LEN-1:0] a2,
    output logic [N_LEN-1:0] quot,
    output logic [D_LEN-1:0] rem,
    output logic             div_zero,
    output logic             fin
);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    localparam logic [CNT_SIZ-1:0] LAST_CNT = CNT_SIZ'(N_LEN - 1);

    state_t             state_q, state_d;
    logic [CNT_SIZ-1:0] cnt_q, cnt_d;
    logic [D_LEN-1:0]   prem_q, prem_d;
    logic [N_LEN-1:0]   dvd_q, dvd_d;
    logic [D_LEN-1:0]   dvs_q, dvs_d;
    logic               dzi_q, dzi_d;
    logic [N_LEN-1:0]   quot_q, quot_d;
    logic [D_LEN-1:0]   rem_q, rem_d;
    logic               dz_q, dz_d;
    logic               fin_q, fin_d;

    logic [N_LEN-1:0]   a1_mag;
    logic [D_LEN-1:0]   a2_mag;
    logic [N_LEN-1:0]   q_res;
    logic [D_LEN-1:0]   r_res;

    // The stored partial remainder is always below the divisor, so D_LEN bits
    // suffice; only the shifted trial value needs the extra bit.
    logic [D_LEN:0]     shifted;
    logic [D_LEN-1:0]   diff;
    logic               ge;

    assign shifted = {prem_q, dvd_q[N_LEN-1]};
    assign ge      = (shifted >= {1'b0, dvs_q});
    assign diff    = shifted[D_LEN-1:0] - dvs_q;

`ifdef SEQDIV_SIGNED_EN
    logic sgn_q_q, sgn_q_d;
    logic sgn_r_q, sgn_r_d;

    assign a1_mag = a1[N_LEN-1] ? -a1 : a1;
    assign a2_mag = a2[D_LEN-1] ? -a2 : a2;
    assign q_res  = sgn_q_q ? -dvd_q : dvd_q;
    assign r_res  = sgn_r_q ? -prem_q : prem_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sgn_q_q <= 1'b0;
            sgn_r_q <= 1'b0;
        end else begin
            sgn_q_q <= sgn_q_d;
            sgn_r_q <= sgn_r_d;
        end
    end

    always_comb begin
        sgn_q_d = sgn_q_q;
        sgn_r_d = sgn_r_q;
        if (arm && state_q == IDLE) begin
            sgn_q_d = a1[N_LEN-1] ^ a2[D_LEN-1];
            sgn_r_d = a1[N_LEN-1];
        end
    end
`else
    assign a1_mag = a1;
    assign a2_mag = a2;
    assign q_res  = dvd_q;
    assign r_res  = prem_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prem_q  <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            dzi_q   <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prem_q  <= prem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            dzi_q   <= dzi_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
            fin_q   <= fin_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prem_d  = prem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        dzi_d   = dzi_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
        fin_d   = fin_q;
        if (!arm) begin
            state_d = IDLE;
            fin_d   = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    dvd_d   = a1_mag;
                    dvs_d   = a2_mag;
                    dzi_d   = (a2 == '0);
                    prem_d  = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
                RUN: begin
                    // Quotient bits shift into the vacated LSBs of the dividend register.
                    prem_d = ge ? diff : shifted[D_LEN-1:0];
                    dvd_d  = {dvd_q[N_LEN-2:0], ge};
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_d = FIX;
                    end
                end
                FIX: begin
                    quot_d  = dzi_q ? '0 : q_res;
                    rem_d   = dzi_q ? '0 : r_res;
                    dz_d    = dzi_q;
                    fin_d   = 1'b1;
                    state_d = DONE;
                end
                DONE: begin
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign quot     = quot_q;
    assign rem      = rem_q;
    assign div_zero = dz_q;
    assign fin      = fin_q;

endmodule

// File: tb/tb_seqdiv.sv
// Directed self-checking bench for seqdiv at N_LEN=D_LEN=8; expectations follow SEQDIV_SIGNED_EN.
module tb_seqdiv;

    logic       clk;
    logic       rst;
    logic       arm;
    logic [7:0] a1;
    logic [7:0] a2;
    logic [7:0] quot;
    logic [7:0] rem;
    logic       div_zero;
    logic       fin;

    int tests;
    int fails;

    seqdiv #(.N_LEN(8), .D_LEN(8), .CNT_SIZ(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .arm      (arm),
        .a1       (a1),
        .a2       (a2),
        .quot     (quot),
        .rem      (rem),
        .div_zero (div_zero),
        .fin      (fin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, tests=%0d", tests);
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic start_op(input logic [7:0] x, input logic [7:0] y);
        a1  = x;
        a2  = y;
        arm = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        arm = 1'b0;
        a1  = 8'h00;
        a2  = 8'h00;
        #1;
        tests++;
        if ({quot, rem, div_zero, fin} !== 18'h0) begin
            fails++;
            $display("FAIL reset_outputs: got quot=%h rem=%h dz=%b fin=%b, want all 0", quot, rem, div_zero, fin);
        end
        tick(2);
        rst = 1'b0;
        tick(1);
        tests++;
        if (fin !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle_fin: got %b want 0", fin);
        end
    endtask

    task automatic test_vectors;
        logic [7:0] va[4];
        logic [7:0] vb[4];
        logic [7:0] eq[4];
        logic [7:0] er[4];
`ifdef SEQDIV_SIGNED_EN
        va = '{8'd100, 8'hF9, 8'h07, 8'h80};
        vb = '{8'd7,   8'h02, 8'hFE, 8'hFF};
        eq = '{8'd14,  8'hFD, 8'hFD, 8'h80};
        er = '{8'd2,   8'hFF, 8'h01, 8'h00};
`else
        va = '{8'd100, 8'hFF, 8'h80, 8'h07};
        vb = '{8'd7,   8'h10, 8'hFF, 8'hFE};
        eq = '{8'd14,  8'h0F, 8'h00, 8'h00};
        er = '{8'd2,   8'h0F, 8'h80, 8'h07};
`endif
        for (int i = 0; i < 4; i++) begin
            start_op(va[i], vb[i]);
            tick(9);
            tests++;
            if (fin !== 1'b0) begin
                fails++;
                $display("FAIL vec%0d_early_fin: got fin=%b after 9 edges want 0", i, fin);
            end
            tick(1);
            tests++;
            if (fin !== 1'b1 || quot !== eq[i] || rem !== er[i] || div_zero !== 1'b0) begin
                fails++;
                $display("FAIL vec%0d_result %h/%h: got fin=%b quot=%h rem=%h dz=%b, want fin=1 quot=%h rem=%h dz=0",
                         i, va[i], vb[i], fin, quot, rem, div_zero, eq[i], er[i]);
            end
            tick(2);
            tests++;
            if (fin !== 1'b1 || quot !== eq[i] || rem !== er[i]) begin
                fails++;
                $display("FAIL vec%0d_done_hold: got fin=%b quot=%h rem=%h, want fin=1 quot=%h rem=%h",
                         i, fin, quot, rem, eq[i], er[i]);
            end
            arm = 1'b0;
            tick(1);
            tests++;
            if (fin !== 1'b0 || quot !== eq[i] || rem !== er[i]) begin
                fails++;
                $display("FAIL vec%0d_disarm: got fin=%b quot=%h rem=%h, want fin=0 quot=%h rem=%h",
                         i, fin, quot, rem, eq[i], er[i]);
            end
        end
    endtask

    task automatic test_div_zero;
        start_op(8'd5, 8'd0);
        tick(10);
        tests++;
        if (fin !== 1'b1 || div_zero !== 1'b1 || quot !== 8'h00 || rem !== 8'h00) begin
            fails++;
            $display("FAIL divzero_result: got fin=%b dz=%b quot=%h rem=%h, want fin=1 dz=1 quot=00 rem=00",
                     fin, div_zero, quot, rem);
        end
        arm = 1'b0;
        tick(1);
        tests++;
        if (fin !== 1'b0 || div_zero !== 1'b1) begin
            fails++;
            $display("FAIL divzero_disarm: got fin=%b dz=%b, want fin=0 dz=1", fin, div_zero);
        end
        start_op(8'd9, 8'd3);
        tick(10);
        tests++;
        if (fin !== 1'b1 || div_zero !== 1'b0 || quot !== 8'd3 || rem !== 8'd0) begin
            fails++;
            $display("FAIL divzero_rearm: got fin=%b dz=%b quot=%h rem=%h, want fin=1 dz=0 quot=03 rem=00",
                     fin, div_zero, quot, rem);
        end
    endtask

    task automatic test_abort;
        arm = 1'b0;
        tick(1);
        start_op(8'd9, 8'd2);
        tick(5);
        arm = 1'b0;
        tick(1);
        tests++;
        if (fin !== 1'b0 || quot !== 8'd3 || rem !== 8'd0) begin
            fails++;
            $display("FAIL abort_hold: got fin=%b quot=%h rem=%h, want fin=0 quot=03 rem=00", fin, quot, rem);
        end
        tick(8);
        tests++;
        if (fin !== 1'b0 || quot !== 8'd3) begin
            fails++;
            $display("FAIL abort_no_fin: got fin=%b quot=%h, want fin=0 quot=03", fin, quot);
        end
    endtask

    task automatic test_operand_change;
        start_op(8'd100, 8'd7);
        tick(1);
        a1 = 8'd3;
        a2 = 8'd1;
        tick(9);
        tests++;
        if (fin !== 1'b1 || quot !== 8'd14 || rem !== 8'd2) begin
            fails++;
            $display("FAIL operand_change: got fin=%b quot=%h rem=%h, want fin=1 quot=0e rem=02", fin, quot, rem);
        end
    endtask

    task automatic test_back_to_back;
        arm = 1'b0;
        tick(1);
        start_op(8'd50, 8'd6);
        tick(10);
        tests++;
        if (fin !== 1'b1 || quot !== 8'd8 || rem !== 8'd2) begin
            fails++;
            $display("FAIL b2b_first: got fin=%b quot=%h rem=%h, want fin=1 quot=08 rem=02", fin, quot, rem);
        end
        arm = 1'b0;
        tick(1);
        start_op(8'd13, 8'd13);
        tick(10);
        tests++;
        if (fin !== 1'b1 || quot !== 8'd1 || rem !== 8'd0) begin
            fails++;
            $display("FAIL b2b_second: got fin=%b quot=%h rem=%h, want fin=1 quot=01 rem=00", fin, quot, rem);
        end
    endtask

    task automatic test_reset_mid_run;
        arm = 1'b0;
        tick(1);
        start_op(8'd100, 8'd7);
        tick(10);
        arm = 1'b0;
        tick(1);
        start_op(8'd9, 8'd2);
        tick(4);
        #2;
        rst = 1'b1;
        arm = 1'b0;
        #1;
        tests++;
        if ({quot, rem, div_zero, fin} !== 18'h0) begin
            fails++;
            $display("FAIL reset_async: got quot=%h rem=%h dz=%b fin=%b, want all 0", quot, rem, div_zero, fin);
        end
        @(negedge clk);
        rst = 1'b0;
        start_op(8'd100, 8'd7);
        tick(10);
        tests++;
        if (fin !== 1'b1 || quot !== 8'd14 || rem !== 8'd2) begin
            fails++;
            $display("FAIL reset_recover: got fin=%b quot=%h rem=%h, want fin=1 quot=0e rem=02", fin, quot, rem);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_vectors();
        test_div_zero();
        test_abort();
        test_operand_change();
        test_back_to_back();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
